serial_flow_acc: RTL and testbench



---
 rtl/serial_flow_acc.sv | 93 +++++++++
 tb/tb_serial_flow_acc.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_flow_acc.sv
// serial_flow_acc: popcount accumulator over serial lines with overflow tracking, idle-timeout FSM and sticky coverage
module serial_flow_acc #(
  parameter int NLINES  = 2,
  parameter int ACC_W   = 3,
  parameter int CNT_W   = 4,
  parameter int IDLE_TO = 4,
  parameter int MODE    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [NLINES-1:0] line,
  input  logic              cov_clr,
  output logic [ACC_W-1:0]  stato,
  output logic              outp,
  output logic              overflw,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic              busy,
  output logic [5:0]        cov
);
  localparam int SUM_W = $clog2(NLINES + 1);
  localparam int IW    = $clog2(IDLE_TO) + 1;
  if (NLINES < 2 || NLINES > 15 || NLINES >= 2 ** ACC_W || IDLE_TO < 1) begin : g_bad_params
    $error("serial_flow_acc: illegal parameter combination");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_nxt;
  logic [SUM_W-1:0] sum;
  logic [ACC_W:0]   nxt;
  logic [ACC_W-1:0] stato_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IW-1:0]    idle, idle_nxt;
  logic [5:0]       ev;
  logic             ovf_nxt, outp_nxt, sat, timeout;
  always_comb begin
    sum = '0;
    for (int i = 0; i < NLINES; i++) sum = sum + SUM_W'(line[i]);
  end
  assign nxt     = {1'b0, stato} + (ACC_W + 1)'(sum);
  assign sat     = &ovf_cnt;
  assign timeout = state == RUN && !en && idle == IW'(IDLE_TO - 1);
  assign busy    = state == RUN;
  assign outp_nxt = en & (MODE != 0 ? (&line) | ~(|line) : ^line);
  always_comb begin
    state_nxt = state;
    stato_nxt = stato;
    idle_nxt  = idle;
    ovf_nxt   = 1'b0;
    cnt_nxt   = ovf_cnt;
    ev        = '0;
    if (state == IDLE && en) begin
      state_nxt = RUN;
      stato_nxt = ACC_W'(sum);
      idle_nxt  = '0;
      ev[0]     = 1'b1;
    end else if (state == RUN && en) begin
      stato_nxt = nxt[ACC_W-1:0];
      ovf_nxt   = nxt[ACC_W];
      idle_nxt  = '0;
      ev[1]     = sum == '0;
      ev[3]     = nxt[ACC_W];
      ev[4]     = nxt[ACC_W] & sat;
      cnt_nxt   = ovf_cnt + CNT_W'(nxt[ACC_W] & ~sat);
    end else if (timeout) begin
      state_nxt = IDLE;
      stato_nxt = '0;
      idle_nxt  = '0;
      ev[5]     = 1'b1;
    end else if (state == RUN) begin
      idle_nxt  = idle + IW'(1);
    end
    ev[2] = en && sum == SUM_W'(NLINES);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      stato   <= '0;
      outp    <= 1'b0;
      overflw <= 1'b0;
      ovf_cnt <= '0;
      idle    <= '0;
      cov     <= '0;
    end else begin
      state   <= state_nxt;
      stato   <= stato_nxt;
      outp    <= outp_nxt;
      overflw <= ovf_nxt;
      ovf_cnt <= cnt_nxt;
      idle    <= idle_nxt;
      cov     <= (cov_clr ? 6'b0 : cov) | ev;
    end
  end
endmodule

// File: tb/tb_serial_flow_acc.sv
// tb_serial_flow_acc: directed stimulus, arithmetic reference model compared every cycle, plus literal checks
module tb_serial_flow_acc;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en0 = 1'b0, clr0 = 1'b0, en1 = 1'b0;
  logic [1:0] line0 = '0;
  logic [2:0] line1 = '0;
  logic [2:0] st0, st1, st2;
  logic [3:0] cnt0, cnt1, cnt2;
  logic [5:0] cov0, cov1, cov2;
  logic o0, o1, o2, v0, v1, v2, b0, b1, b2;
  int checks = 0, errors = 0;
  bit go = 0;
  int m_st[3], m_out[3], m_ovf[3], m_cnt[3], m_busy[3], m_idle[3], m_cov[3];
  int nl[3] = '{2, 3, 3};
  int md[3] = '{0, 1, 0};

  serial_flow_acc dut0 (.clock(clock), .reset(reset), .en(en0), .line(line0), .cov_clr(clr0),
    .stato(st0), .outp(o0), .overflw(v0), .ovf_cnt(cnt0), .busy(b0), .cov(cov0));
  serial_flow_acc #(.NLINES(3), .MODE(1)) dut1 (.clock(clock), .reset(reset), .en(en1), .line(line1),
    .cov_clr(1'b0), .stato(st1), .outp(o1), .overflw(v1), .ovf_cnt(cnt1), .busy(b1), .cov(cov1));
  serial_flow_acc #(.NLINES(3), .MODE(0)) dut2 (.clock(clock), .reset(reset), .en(en1), .line(line1),
    .cov_clr(1'b0), .stato(st2), .outp(o2), .overflw(v2), .ovf_cnt(cnt2), .busy(b2), .cov(cov2));

  always #5 clock = ~clock;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, a, e);
    end
  endtask

  // Reference: ACC_W=3 (modulus 8), CNT_W=4 (saturates at 15), IDLE_TO=4
  task automatic mstep(int i, bit e, int l, bit c);
    int s, t, ev;
    s = $countones(l);
    ev = 0;
    m_out[i] = e ? (md[i] != 0 ? int'(s == nl[i] || s == 0) : s % 2) : 0;
    m_ovf[i] = 0;
    if (!m_busy[i]) begin
      if (e) begin
        m_st[i] = s;
        m_busy[i] = 1;
        m_idle[i] = 0;
        ev |= 1;
      end
    end else if (e) begin
      t = m_st[i] + s;
      m_ovf[i] = int'(t >= 8);
      m_st[i] = t % 8;
      m_idle[i] = 0;
      if (s == 0) ev |= 2;
      if (m_ovf[i] != 0) begin
        ev |= 8;
        if (m_cnt[i] == 15) ev |= 16;
        else m_cnt[i]++;
      end
    end else if (m_idle[i] == 3) begin
      m_busy[i] = 0;
      m_st[i] = 0;
      m_idle[i] = 0;
      ev |= 32;
    end else m_idle[i]++;
    if (e && s == nl[i]) ev |= 4;
    m_cov[i] = (c ? 0 : m_cov[i]) | ev;
  endtask

  always @(posedge clock or negedge reset)
    for (int i = 0; i < 3; i++)
      if (!reset) begin
        m_st[i] = 0; m_out[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
        m_busy[i] = 0; m_idle[i] = 0; m_cov[i] = 0;
      end else mstep(i, i == 0 ? en0 : en1, i == 0 ? int'(line0) : int'(line1), i == 0 ? clr0 : 1'b0);

  task automatic cmp(int i, int s, int o, int v, int c, int b, int cv);
    chk($sformatf("stato%0d", i), s, m_st[i]);
    chk($sformatf("outp%0d", i), o, m_out[i]);
    chk($sformatf("overflw%0d", i), v, m_ovf[i]);
    chk($sformatf("ovf_cnt%0d", i), c, m_cnt[i]);
    chk($sformatf("busy%0d", i), b, m_busy[i]);
    chk($sformatf("cov%0d", i), cv, m_cov[i]);
  endtask

  always @(negedge clock) if (go) begin
    cmp(0, int'(st0), int'(o0), int'(v0), int'(cnt0), int'(b0), int'(cov0));
    cmp(1, int'(st1), int'(o1), int'(v1), int'(cnt1), int'(b1), int'(cov1));
    cmp(2, int'(st2), int'(o2), int'(v2), int'(cnt2), int'(b2), int'(cov2));
  end

  task automatic cyc(bit e, logic [1:0] l, bit c = 1'b0);
    en0 = e;
    line0 = l;
    clr0 = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    go = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_stato", int'(st0), 0);
    chk("rst_busy", int'(b0), 0);
    chk("rst_cov", int'(cov0), 0);
    // four samples of 11 wrap 2,4,6,0
    cyc(1, 2'b11); chk("acc1", int'(st0), 2);
    cyc(1, 2'b11); chk("acc2", int'(st0), 4);
    cyc(1, 2'b11); chk("acc3", int'(st0), 6); chk("no_ovf3", int'(v0), 0);
    cyc(1, 2'b11); chk("acc4", int'(st0), 0); chk("ovf4", int'(v0), 1);
    chk("cnt4", int'(cnt0), 1); chk("cov4", int'(cov0), 6'b001101);
    cyc(1, 2'b01); cyc(1, 2'b01); cyc(1, 2'b01);
    chk("to_stato3", int'(st0), 3);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 2'b00); chk("to_busy", int'(b0), 1); chk("to_hold", int'(st0), 3);
    end
    cyc(0, 2'b00);
    chk("to_idle", int'(b0), 0); chk("to_zero", int'(st0), 0); chk("to_cov5", int'(cov0[5]), 1);
    cyc(1, 2'b01); cyc(1, 2'b01); cyc(1, 2'b01);
    cyc(0, 2'b00); cyc(0, 2'b00); cyc(1, 2'b00);
    chk("restart_st", int'(st0), 3);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 2'b00); chk("restart_busy", int'(b0), 1);
    end
    cyc(0, 2'b00); chk("restart_to", int'(b0), 0);
    repeat (4) cyc(1, 2'b11);
    cyc(1, 2'b11); cyc(1, 2'b11); cyc(1, 2'b01);
    chk("pre_rst_st", int'(st0), 5); chk("pre_rst_cnt", int'(cnt0), 2); chk("pre_rst_busy", int'(b0), 1);
    en0 = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_st", int'(st0), 0); chk("arst_cnt", int'(cnt0), 0); chk("arst_busy", int'(b0), 0);
    chk("arst_outp", int'(o0), 0); chk("arst_cov", int'(cov0), 0);
    @(negedge clock);
    reset = 1'b1;
    cyc(1, 2'b11); cyc(1, 2'b00);
    chk("cov_pre", int'(cov0), 6'b000111); chk("cov_pre_st", int'(st0), 2);
    repeat (5) cyc(1, 2'b01);
    chk("st7", int'(st0), 7);
    cyc(1, 2'b01, 1'b1);
    chk("clr_set_cov", int'(cov0), 6'b001000); chk("clr_ovf", int'(v0), 1); chk("clr_cnt", int'(cnt0), 1);
    for (int k = 0; k < 64; k++) begin
      cyc(1, 2'b11);
      if (k == 55) begin
        chk("sat_reach", int'(cnt0), 15); chk("sat_cov4_clear", int'(cov0[4]), 0);
      end
    end
    chk("sat_cnt", int'(cnt0), 15); chk("sat_ovf", int'(v0), 1); chk("sat_cov4", int'(cov0[4]), 1);
    en0 = 1'b0;
    en1 = 1'b1;
    line1 = 3'b111; @(posedge clock); #1;
    chk("m1_111", int'(o1), 1); chk("m0_111", int'(o2), 1);
    line1 = 3'b010; @(posedge clock); #1;
    chk("m1_010", int'(o1), 0); chk("m0_010", int'(o2), 1);
    line1 = 3'b000; @(posedge clock); #1;
    chk("m1_000", int'(o1), 1); chk("m0_000", int'(o2), 0);
    en1 = 1'b0;
    @(posedge clock); #1;
    chk("m1_off", int'(o1), 0);
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
